// File: rtl/unpack16_8.sv
// Width down-converter: one 16-bit word in on a valid/ready port, two 8-bit bytes out on a
// valid/ready port. Byte order is chosen by MSB_FIRST. out_last marks the second byte.
module unpack16_8 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_value,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshake rules on both ports:
   // - A transfer happens on a rising edge where valid and ready are both high.
   // - A valid source holds its data stable until that transfer.
   // - in_ready depends combinationally on out_ready in BYTE1 only. Upstream must
   //   therefore never derive in_valid from in_ready.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BYTE0 = 2'd1,
      BYTE1 = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] word_q;
   logic [7:0]  out_value_q;
   logic        out_valid_q;
   logic        out_last_q;
   logic        in_xfer;
   logic        out_xfer;

   function automatic logic [7:0] first_byte(input logic [15:0] w);
      return MSB_FIRST ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] second_byte(input logic [15:0] w);
      return MSB_FIRST ? w[7:0] : w[15:8];
   endfunction

   // A new word is taken either when idle or while the second byte leaves.
   // This lets a stream run at one byte per cycle without bubbles.
   assign in_ready = ~reset & ((state_q == EMPTY) | ((state_q == BYTE1) & out_ready));
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid_q & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         word_q      <= 16'h0000;
         out_value_q <= 8'h00;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  state_q     <= BYTE0;
                  word_q      <= in_value;
                  out_value_q <= first_byte(in_value);
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
               end
            end
            BYTE0: begin
               if (out_xfer) begin
                  state_q     <= BYTE1;
                  out_value_q <= second_byte(word_q);
                  out_last_q  <= 1'b1;
               end
            end
            BYTE1: begin
               if (out_xfer) begin
                  if (in_xfer) begin
                     state_q     <= BYTE0;
                     word_q      <= in_value;
                     out_value_q <= first_byte(in_value);
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                  end else begin
                     state_q     <= EMPTY;
                     out_value_q <= 8'h00;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= EMPTY;
               out_value_q <= 8'h00;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_value = out_value_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != EMPTY);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_unpack16_8.sv
// Bench for unpack16_8: one MSB-first and one LSB-first instance share the stimulus.
// Expected bytes are queued per accepted word and compared by an independent monitor.
module tb_unpack16_8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_value;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [7:0]  out_value_m;
   logic [1:0]  dbg_m;
   logic        in_ready_l, out_valid_l, out_last_l, busy_l;
   logic [7:0]  out_value_l;
   logic [1:0]  dbg_l;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [8:0]  exp_q[$];
   logic [8:0]  exp_l_q[$];
   logic [15:0] stim_q[$];
   int          or_mode = 0;
   logic        or_level = 1'b1;
   logic        take = 1'b0;

   unpack16_8 #(.MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
      .in_ready(in_ready_m), .out_value(out_value_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m), .dbg_state(dbg_m)
   );

   unpack16_8 #(.MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
      .in_ready(in_ready_l), .out_value(out_value_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l), .dbg_state(dbg_l)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a held word is just the bytes still owed. Two owed bytes means
   // nothing can be accepted. One owed byte means a word is accepted when that byte leaves.
   task automatic check_dut(input string tag, input int qsize, input logic [8:0] front,
                            input logic ir, input logic ov, input logic ol,
                            input logic [7:0] val, input logic bz);
      check({tag, ".out_valid"}, 16'(ov), 16'(qsize != 0));
      check({tag, ".busy"}, 16'(bz), 16'(qsize != 0));
      check({tag, ".in_ready"}, 16'(ir), 16'((qsize == 0) || (qsize == 1 && out_ready)));
      if (qsize != 0) check({tag, ".byte"}, 16'({ol, val}), 16'(front));
      else            check({tag, ".idle_byte"}, 16'({ol, val}), 16'h0000);
   endtask

   // driver: presents the stimulus queue head and records accepted words
   initial begin
      logic [15:0] w;
      in_valid  = 1'b0;
      in_value  = 16'h0000;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (stim_q.size() > 0 && !reset) begin
            in_valid = 1'b1;
            in_value = stim_q[0];
         end else begin
            in_valid = 1'b0;
            in_value = 16'($urandom);
         end
         out_ready = (or_mode != 0) ? 1'($urandom_range(0, 1)) : or_level;
         #4;
         take = in_valid && in_ready_m && !reset;
         @(posedge clk);
         #1;
         if (take && !reset && stim_q.size() > 0) begin
            w = stim_q.pop_front();
            exp_q.push_back({1'b0, w[15:8]});
            exp_q.push_back({1'b1, w[7:0]});
            exp_l_q.push_back({1'b0, w[7:0]});
            exp_l_q.push_back({1'b1, w[15:8]});
         end
         take = 1'b0;
      end
   end

   // monitor: compares both instances just before every rising edge
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!reset) begin
            check_dut("msb", exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 9'h000,
                      in_ready_m, out_valid_m, out_last_m, out_value_m, busy_m);
            check_dut("lsb", exp_l_q.size(), (exp_l_q.size() > 0) ? exp_l_q[0] : 9'h000,
                      in_ready_l, out_valid_l, out_last_l, out_value_l, busy_l);
            if (out_ready && exp_q.size() > 0)   void'(exp_q.pop_front());
            if (out_ready && exp_l_q.size() > 0) void'(exp_l_q.pop_front());
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0 || exp_l_q.size() != 0) && n < budget) begin
         @(posedge clk);
         #3;
         n++;
      end
      check("drain_timeout", 16'(n < budget), 16'h0001);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic wait_pending(input int count);
      int n = 0;
      while (exp_q.size() != count && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("pending_timeout", 16'(n < 50), 16'h0001);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".m_valid"}, 16'(out_valid_m), 16'h0000);
      check({tag, ".m_value"}, 16'(out_value_m), 16'h0000);
      check({tag, ".m_last"},  16'(out_last_m),  16'h0000);
      check({tag, ".m_busy"},  16'(busy_m),      16'h0000);
      check({tag, ".m_ready"}, 16'(in_ready_m),  16'h0000);
      check({tag, ".l_valid"}, 16'(out_valid_l), 16'h0000);
      check({tag, ".l_busy"},  16'(busy_l),      16'h0000);
      check({tag, ".l_ready"}, 16'(in_ready_l),  16'h0000);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      reset = 1'b0;

      // single word
      stim_q.push_back(16'hA55A);
      wait_idle(50);

      // back-to-back streaming
      stim_q.push_back(16'h0102);
      stim_q.push_back(16'h0304);
      stim_q.push_back(16'h0506);
      wait_idle(50);

      // backpressure on the first byte
      or_level = 1'b1;
      stim_q.push_back(16'hBEEF);
      wait_pending(2);
      or_level = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      or_level = 1'b1;
      wait_idle(50);

      // byte order (checked on the LSB-first instance)
      stim_q.push_back(16'h1234);
      wait_idle(50);

      // stall in BYTE1 with the next word pending upstream
      or_level = 1'b0;
      stim_q.push_back(16'hCAFE);
      stim_q.push_back(16'h7788);
      wait_pending(2);
      repeat (2) @(posedge clk);
      #2;
      or_level = 1'b1;
      @(posedge clk);
      #2;
      or_level = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      or_level = 1'b1;
      wait_idle(50);

      // asynchronous reset while the first byte of a word is shown
      or_level = 1'b0;
      stim_q.push_back(16'hDEAD);
      wait_pending(2);
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      stim_q.delete();
      exp_q.delete();
      exp_l_q.delete();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      or_level = 1'b1;
      repeat (4) @(posedge clk);
      #2;

      // randomized traffic with random backpressure
      or_mode = 1;
      for (int i = 0; i < 300; i++) begin
         stim_q.push_back(16'($urandom));
         repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      wait_idle(5000);
      or_mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/unpack16_8.md
# unpack16_8

Width down-converter that accepts 16-bit words on a valid/ready input port and emits them as two consecutive 8-bit bytes on a valid/ready output port. It is the transmit-side counterpart of the team's 8-to-16 packer and sits between 16-bit datapath logic and 8-bit byte-serial links. The block sustains one byte per cycle (one word every two cycles) with no bubbles under continuous traffic, and holds its output stable under downstream backpressure.

## Interface
- MSB_FIRST, default 1: 1 emits bits [15:8] first and then bits [7:0]; 0 emits bits [7:0] first and then bits [15:8].
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_value  in  16  word to serialise; sampled only on an input handshake.
- in_valid  in  1  upstream has a word on in_value.
- in_ready  out  1  block can accept a word this cycle.
- out_value  out  8  current byte.
- out_valid  out  1  out_value holds a valid byte.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_last  out  1  high with the second byte of each word.
- busy  out  1  a word is held (state is not EMPTY).

## Operation
- Handshakes:
  - Input transfer (in_xfer) = in_valid & in_ready at a rising edge.
  - Output transfer (out_xfer) = out_valid & out_ready at a rising edge.
- Storage: one 16-bit holding register word_q and a 2-bit state.
- States and transitions:
  - EMPTY: out_valid=0, in_ready=1. On in_xfer, load word_q and go to BYTE0.
  - BYTE0: out_valid=1, out_value is the first byte of word_q, out_last=0, in_ready=0.
    - On out_xfer, go to BYTE1.
    - Otherwise hold.
  - BYTE1: out_valid=1, out_value is the second byte, out_last=1, in_ready=out_ready.
    - On out_xfer with in_xfer in the same cycle, load the new word_q and go to BYTE0 (back-to-back, no bubble).
    - On out_xfer alone, go to EMPTY.
    - Otherwise hold.
- The in_ready path from out_ready in BYTE1 is combinational by design. Upstream must not make in_valid depend on in_ready.
- Byte selection:
  - MSB_FIRST=1: first byte = word_q[15:8], second byte = word_q[7:0].
  - MSB_FIRST=0: the order is swapped.
- out_value is 8'h00 whenever out_valid=0. It is never X or stale.
- in_value is ignored whenever in_ready=0. A word presented in BYTE0 waits upstream and is not lost.
- Backpressure: while out_valid=1 and out_ready=0, out_value, out_last and word_q hold unchanged.
- out_ready is a don't-care in EMPTY.
- busy = (state != EMPTY).
- Reset while asserted: state=EMPTY, word_q=16'h0000, out_valid=0, out_value=8'h00, out_last=0, busy=0, in_ready=0.
- After reset deasserts: in_ready=1 from the first cycle.
- Reset mid-word discards the held word. No partial byte is emitted after release.

## Timing
- Latency: a word accepted at edge N presents its first byte as valid in cycle N+1, i.e. after edge N.
- Without backpressure:
  - Second byte in cycle N+2.
  - A next word accepted at edge N+2 gives its first byte in cycle N+3.
- Throughput: 1 byte/cycle with out_ready held high and in_valid held high.
- Minimum spacing between input handshakes is 2 cycles.
- in_ready never asserts in BYTE0.
- All outputs are decoded from state and word_q only, except in_ready in BYTE1.
- Reset assertion takes effect without a clock edge.

## Test plan
- Single word: reset, then present in_value=16'hA55A for one handshake with out_ready=1, MSB_FIRST=1.
  - Required: bytes 8'hA5 (out_last=0), then 8'h5A (out_last=1) on consecutive cycles.
  - Then out_valid=0, out_value=8'h00, busy=0.
- Streaming: words 16'h0102, 16'h0304, 16'h0506 with in_valid and out_ready held high.
  - Required: bytes 01,02,03,04,05,06 on six consecutive cycles with no gap.
  - in_ready must be low exactly on the cycles showing 01, 03 and 05.
- Backpressure: send word 16'hBEEF, then drop out_ready for 3 cycles while 8'hBE is shown.
  - Required: 8'hBE held stable with out_valid=1 for the 3 cycles.
  - Required: in_ready=0 throughout; 8'hEF appears after out_ready rises.
- Order parameter: MSB_FIRST=0, word 16'h1234.
  - Required: 8'h34 then 8'h12, with out_last high on 8'h12.
- Stall in BYTE1 with upstream pending: in BYTE1 holding 16'hCAFE's second byte, hold out_ready=0 with in_valid=1 and in_value=16'h7788.
  - Required: in_ready=0 and 16'h7788 not taken until out_ready=1.
  - Then the 8'hFE handshake and the 16'h7788 load happen on the same edge, followed by 8'h77.
- Reset mid-operation: assert reset asynchronously while in BYTE0 of 16'hDEAD.
  - Required: out_valid=0, out_value=8'h00 and busy=0 immediately.
  - After release, no 8'hAD is emitted and in_ready=1.
